regfile_wb_scheduler: RTL



---
 rtl/regfile_wb_scheduler_pkg.sv | 17 +
 rtl/regfile_wb_scheduler_scoreboard.sv | 49 ++++
 rtl/regfile_wb_scheduler.sv | 121 ++++++++++++
 3 files changed

// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared core definitions for the regfile writeback scheduler:
// default widths, the zero-register constant and the write-source tag.
package regfile_wb_scheduler_pkg;

    localparam int WIDTH_DEF      = 32;
    localparam int ADDR_WIDTH_DEF = 5;

    localparam logic [ADDR_WIDTH_DEF-1:0] REG_ZERO = '0;

    // Tag carried with the registered write so the scoreboard knows
    // whether the write retires an outstanding long-latency result.
    typedef enum logic {
        WB_ALU  = 1'b0,
        WB_LONG = 1'b1
    } wb_src_e;

endpackage

// File: rtl/regfile_wb_scheduler_scoreboard.sv
// Pending-write scoreboard: one bit per register, set/clear ports,
// hazard lookup for rs1/rs2/rd and a pending lookup for a returning rd.
// Ports: clk, rst (async active-low), set_*, clr_*, issue lookup
// (rs1/rs2/rd + use flags) -> hazard, lk_addr -> lk_pending.
module regfile_scoreboard
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DEPTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_addr,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic                  use_rs1,
    input  logic                  use_rs2,
    output logic                  hazard,
    input  logic [ADDR_WIDTH-1:0] lk_addr,
    output logic                  lk_pending
);

    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pending_nxt;

    // Clear applied first so a same-edge set on the same register wins.
    always_comb begin
        pending_nxt = pending;
        if (clr_en) pending_nxt[clr_addr] = 1'b0;
        if (set_en) pending_nxt[set_addr] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pending <= '0;
        else      pending <= pending_nxt;
    end

    assign hazard = (use_rs1 & pending[rs1])
                  | (use_rs2 & pending[rs2])
                  | pending[rd];

    assign lk_pending = pending[lk_addr];

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Regfile write-port scheduler: arbitrates ALU vs long-latency writeback,
// tracks outstanding long results and stalls issue on RAW/WAW/starvation.
// Ports: clk, rst (async active-low), issue_* / stall, alu_*, lsu_* /
// lsu_ready, we0/wr_addr0/wr_din0 to the regfile, sticky wb_err.
module regfile_wb_scheduler
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int WIDTH        = WIDTH_DEF,
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int DEPTH        = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic                  issue_long,
    input  logic [ADDR_WIDTH-1:0] issue_rs1,
    input  logic [ADDR_WIDTH-1:0] issue_rs2,
    input  logic                  issue_use_rs1,
    input  logic                  issue_use_rs2,
    output logic                  stall,
    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [WIDTH-1:0]      alu_data,
    input  logic                  lsu_valid,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [WIDTH-1:0]      lsu_data,
    output logic                  lsu_ready,
    output logic                  we0,
    output logic [ADDR_WIDTH-1:0] wr_addr0,
    output logic [WIDTH-1:0]      wr_din0,
    output logic                  wb_err
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_WIDTH-1:0] RZ = ADDR_WIDTH'(REG_ZERO);

    wb_src_e       wr_src;
    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] starve_nxt;
    logic          drain;
    logic          hazard;
    logic          lsu_pend;
    logic          accept;
    logic          refused;

    assign lsu_ready = lsu_valid & ~alu_valid;
    assign refused   = lsu_valid & ~lsu_ready;
    assign stall     = issue_valid & (hazard | drain);
    assign accept    = issue_valid & ~stall;

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .set_en     (accept & issue_long & (issue_rd != RZ)),
        .set_addr   (issue_rd),
        .clr_en     (we0 & (wr_src == WB_LONG)),
        .clr_addr   (wr_addr0),
        .rs1        (issue_rs1),
        .rs2        (issue_rs2),
        .rd         (issue_rd),
        .use_rs1    (issue_use_rs1),
        .use_rs2    (issue_use_rs2),
        .hazard     (hazard),
        .lk_addr    (lsu_rd),
        .lk_pending (lsu_pend)
    );

    // Registered write port: one cycle from acceptance to regfile write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we0      <= 1'b0;
            wr_addr0 <= '0;
            wr_din0  <= '0;
            wr_src   <= WB_ALU;
        end else if (alu_valid) begin
            we0      <= (alu_rd != RZ);
            wr_addr0 <= alu_rd;
            wr_din0  <= alu_data;
            wr_src   <= WB_ALU;
        end else if (lsu_valid) begin
            we0      <= (lsu_rd != RZ);
            wr_addr0 <= lsu_rd;
            wr_din0  <= lsu_data;
            wr_src   <= WB_LONG;
        end else begin
            we0      <= 1'b0;
        end
    end

    always_comb begin
        starve_nxt = '0;
        if (refused) begin
            if (starve_cnt < CW'(STARVE_LIMIT)) starve_nxt = starve_cnt + 1'b1;
            else                                starve_nxt = starve_cnt;
        end
    end

    // drain rises together with the counter reaching the limit and
    // only drops once the long writeback finally gets the port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
            drain      <= 1'b0;
            wb_err     <= 1'b0;
        end else begin
            starve_cnt <= starve_nxt;
            if (lsu_ready)
                drain <= 1'b0;
            else if (starve_nxt == CW'(STARVE_LIMIT))
                drain <= 1'b1;
            if (lsu_ready && (lsu_rd != RZ) && !lsu_pend)
                wb_err <= 1'b1;
        end
    end

endmodule
